// File: rtl/pcount_history.sv
// Pulse-count history buffer: keeps the last DEPTH samples in a shift chain,
// maintains an incremental window sum and fill level, and produces a rounded
// window average one cycle after each shift for the display/alarm path.

module pcount_history #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   iden,
  input  logic                                   clr,
  input  logic [WIDTH-1:0]                       q_in,
  output logic [DEPTH*WIDTH-1:0]                 taps,
  output logic [WIDTH+$clog2(DEPTH)-1:0]         sum,
  output logic [$clog2(DEPTH+1)-1:0]             fill,
  output logic                                   full,
  output logic [WIDTH-1:0]                       avg,
  output logic                                   avg_valid,
  output logic                                   upd
);

  localparam int SW = WIDTH + $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(DEPTH);

  // Reject windows that are not a power of two or too small to average.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("pcount_history: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] slot_r [DEPTH];
  logic [SW-1:0]    sum_r;
  logic [FW-1:0]    fill_r;
  logic             pend_r;
  logic [WIDTH-1:0] avg_r;
  logic             avg_valid_r;
  logic             upd_r;

  logic [SW-1:0]    sum_next_s;
  logic [FW-1:0]    fill_next_s;
  logic             full_s;
  logic [WIDTH-1:0] avg_round_s;

  // Next-state arithmetic for the window: the sum adds the incoming sample and
  // drops the oldest slot; empty slots hold 0 so this is exact while filling.
  always_comb begin
    sum_next_s  = sum_r + SW'(q_in) - SW'(slot_r[DEPTH-1]);
    full_s      = (fill_r == FW'(DEPTH));
    if (full_s) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + FW'(1);
    end
    // Max sum + DEPTH/2 stays below 2^SW, so the rounded mean fits WIDTH bits.
    avg_round_s = WIDTH'((sum_r + SW'(DEPTH / 2)) >> LW);
  end

  // Window shift chain, running sum and fill level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_r[k] <= {WIDTH{1'b0}};
      end
      sum_r  <= {SW{1'b0}};
      fill_r <= {FW{1'b0}};
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_r[k] <= {WIDTH{1'b0}};
      end
      sum_r  <= {SW{1'b0}};
      fill_r <= {FW{1'b0}};
    end else if (iden) begin
      slot_r[0] <= q_in;
      for (int k = 1; k < DEPTH; k++) begin
        slot_r[k] <= slot_r[k-1];
      end
      sum_r  <= sum_next_s;
      fill_r <= fill_next_s;
    end else begin
      sum_r  <= sum_r;
      fill_r <= fill_r;
    end
  end

  // Average stage: runs one edge after each shift so it sees the updated sum;
  // upd is raised in the same cycle the new avg becomes visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r      <= 1'b0;
      avg_r       <= {WIDTH{1'b0}};
      avg_valid_r <= 1'b0;
      upd_r       <= 1'b0;
    end else if (clr) begin
      pend_r      <= 1'b0;
      avg_r       <= {WIDTH{1'b0}};
      avg_valid_r <= 1'b0;
      upd_r       <= 1'b0;
    end else begin
      pend_r <= iden;
      upd_r  <= pend_r;
      if (pend_r) begin
        avg_r       <= avg_round_s;
        avg_valid_r <= full_s;
      end else begin
        avg_r       <= avg_r;
        avg_valid_r <= avg_valid_r;
      end
    end
  end

  // Flatten the slot array onto the taps bus, slot 0 in the low bits.
  always_comb begin
    taps = {(DEPTH*WIDTH){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      taps[k*WIDTH +: WIDTH] = slot_r[k];
    end
  end

  assign sum       = sum_r;
  assign fill      = fill_r;
  assign full      = full_s;
  assign avg       = avg_r;
  assign avg_valid = avg_valid_r;
  assign upd       = upd_r;

  pcount_history_chk #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .taps (taps),
    .sum  (sum_r),
    .fill (fill_r)
  );

endmodule

// Simulation checker: the running sum must always equal the sum of the slots,
// and the fill level must never exceed the window depth.
module pcount_history_chk #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic                               clk,
  input logic                               rst,
  input logic [DEPTH*WIDTH-1:0]             taps,
  input logic [WIDTH+$clog2(DEPTH)-1:0]     sum,
  input logic [$clog2(DEPTH+1)-1:0]         fill
);

  localparam int SW = WIDTH + $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic [SW-1:0] tap_sum_s;

  // Reference sum recomputed from the slots.
  always_comb begin
    tap_sum_s = {SW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      tap_sum_s = tap_sum_s + SW'(taps[k*WIDTH +: WIDTH]);
    end
  end

  a_sum_invariant: assert property (@(posedge clk) disable iff (!rst) sum == tap_sum_s)
    else $error("sum invariant violated: sum=%0d slots=%0d", sum, tap_sum_s);

  a_fill_bound: assert property (@(posedge clk) disable iff (!rst) fill <= FW'(DEPTH))
    else $error("fill exceeds depth: %0d", fill);

endmodule

// File: tb/tb_pcount_history.sv
// Scoreboard bench for pcount_history (WIDTH=4, DEPTH=4): each shift pushes the
// hand-computed avg/avg_valid it should produce; a monitor pops on every upd.
module tb_pcount_history;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        iden;
  logic        clr;
  logic [3:0]  q_in;
  logic [15:0] taps;
  logic [5:0]  sum;
  logic [2:0]  fill;
  logic        full;
  logic [3:0]  avg;
  logic        avg_valid;
  logic        upd;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q [$];   // {avg_valid, avg}

  pcount_history #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .iden      (iden),
    .clr       (clr),
    .q_in      (q_in),
    .taps      (taps),
    .sum       (sum),
    .fill      (fill),
    .full      (full),
    .avg       (avg),
    .avg_valid (avg_valid),
    .upd       (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every upd pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst === 1'b1 && upd === 1'b1) begin
      check("upd_has_expect", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("avg", 32'(avg), 32'(e[3:0]));
        check("avg_valid", 32'(avg_valid), 32'(e[4]));
      end
    end
  end

  task automatic shift(input logic [3:0] q, input logic [5:0] esum, input logic [2:0] efill,
                       input logic [3:0] eavg, input logic evalid);
    @(negedge clk);
    iden = 1'b1;
    clr  = 1'b0;
    q_in = q;
    exp_q.push_back({evalid, eavg});
    @(posedge clk);
    #1;
    check("slot0", 32'(taps[3:0]), 32'(q));
    check("sum", 32'(sum), 32'(esum));
    check("fill", 32'(fill), 32'(efill));
    check("full", 32'(full), 32'(efill == 3'd4));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iden = 1'b0;
      clr  = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_taps"}, 32'(taps), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'd0);
    check({tag, "_fill"}, 32'(fill), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_avg"}, 32'(avg), 32'd0);
    check({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
    check({tag, "_upd"}, 32'(upd), 32'd0);
  endtask

  logic [5:0] t4_sum [10] = '{6'd46, 6'd54, 6'd60, 6'd60, 6'd60, 6'd60, 6'd60, 6'd60, 6'd60, 6'd60};
  logic [3:0] t4_avg [10] = '{4'd12, 4'd14, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset held while iden toggles with data
    rst  = 1'b0;
    iden = 1'b1;
    clr  = 1'b0;
    q_in = 4'd9;
    repeat (3) @(posedge clk);
    #1;
    check_zero("t1_in_reset");
    @(negedge clk);
    iden = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    check_zero("t1_after_reset");

    // T2: fill with 3,5,7,9
    shift(4'd3, 6'd3,  3'd1, 4'd1, 1'b0);
    shift(4'd5, 6'd8,  3'd2, 4'd2, 1'b0);
    shift(4'd7, 6'd15, 3'd3, 4'd4, 1'b0);
    shift(4'd9, 6'd24, 3'd4, 4'd6, 1'b1);

    // T3: slide in 15, oldest 3 drops
    shift(4'd15, 6'd36, 3'd4, 4'd9, 1'b1);
    check("t3_taps", 32'(taps), 32'h579F);

    // T4: ten back-to-back max samples
    for (int i = 0; i < 10; i++) begin
      shift(4'd15, t4_sum[i], 3'd4, t4_avg[i], 1'b1);
    end
    check("t4_taps", 32'(taps), 32'hFFFF);
    idle(2);
    check("t4_avg_final", 32'(avg), 32'd15);

    // T5: clr together with iden on a full window
    @(negedge clk);
    clr  = 1'b1;
    iden = 1'b1;
    q_in = 4'd7;
    @(posedge clk);
    #1;
    check_zero("t5_clr");
    @(negedge clk);
    clr  = 1'b0;
    iden = 1'b0;
    @(posedge clk);
    #1;
    check_zero("t5_after");

    // T6: async reset between edges after two samples
    shift(4'd4, 6'd4,  3'd1, 4'd1, 1'b0);
    shift(4'd6, 6'd10, 3'd2, 4'd3, 1'b0);
    @(negedge clk);
    iden = 1'b0;
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_zero("t6_async");
    @(negedge clk);
    rst = 1'b1;
    shift(4'd11, 6'd11, 3'd1, 4'd3, 1'b0);
    check("t6_taps", 32'(taps), 32'h000B);
    idle(3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
